sum_accumulator: RTL
====================

# sum_accumulator

Registered accumulator that sits directly downstream of the N-bit adder and consumes its N+1-bit `Out` result.
- Sums COUNT accepted adder results into one ACC_W-bit frame total, with saturation.
- Presents each total on a valid/ready output port.
- Uses valid/ready on both sides, so the combinational adder can be fed from a stalling source and drained by a stalling sink.

## Interface
- N, 8: adder operand width; input sum is N+1 bits.
- COUNT, 4: adder results per frame; legal range 1..255.
- ACC_W, 11: accumulator width; must be ≥ N+1.
- Clk  input  1  single clock; all state updates on rising edge.
- Rst_N  input  1  asynchronous, active-low reset.
- In_Sum  input  N+1  adder result (zero-extended unsigned).
- In_Valid  input  1  In_Sum is valid this cycle.
- In_Ready  output  1  block can accept In_Sum this cycle.
- Clear  input  1  synchronous frame abort; highest priority after reset.
- Out_Acc  output  ACC_W  frame total; meaningful only while Out_Valid=1.
- Out_Sat  output  1  frame total saturated; qualified by Out_Valid.
- Out_Valid  output  1  frame total available.
- Out_Ready  input  1  sink accepts frame total.

## Operation
- States:
  - IDLE: acc=0, cnt=0.
  - ACCUM: frame in progress.
  - DONE: total held for the sink.
- In_Ready=1 in IDLE and ACCUM, 0 in DONE. It is a combinational decode of state only and never depends on In_Valid.
- Out_Valid=1 only in DONE.
- Accept = In_Valid & In_Ready.
- IDLE + accept:
  - acc←In_Sum, cnt←1.
  - Next state: DONE if COUNT=1, else ACCUM.
- ACCUM + accept:
  - acc←sat(acc+In_Sum), cnt←cnt+1.
  - Next state: DONE when the new cnt equals COUNT, else stay in ACCUM.
- No accept: state, acc and cnt hold.
- DONE + Out_Ready: go to IDLE; acc, cnt and Out_Sat clear.
- DONE without Out_Ready: Out_Acc and Out_Sat hold stable.
- Arithmetic: unsigned, ACC_W+1-bit internal sum. If the sum exceeds 2^ACC_W−1, acc←2^ACC_W−1 and the sticky sat flag is set for the rest of the frame.
- Clear=1 in any state: next state IDLE, acc=0, cnt=0, sat=0.
  - Any same-cycle accept is discarded.
  - A pending DONE frame is dropped and never handshaken.
- Rst_N=0 at any time, including mid-frame: immediately forces IDLE, acc=0, cnt=0, sat=0, Out_Valid=0.

## Timing
- Reset values: Out_Acc=0, Out_Sat=0, Out_Valid=0, In_Ready=1 (IDLE).
- Latency: Out_Valid rises on the first edge after the COUNT-th accept, i.e. the cycle following the accepting cycle.
- Throughput: at most one frame per COUNT+1 cycles, because DONE blocks input for at least one cycle.
- Back-to-back beats: one accept per cycle in IDLE/ACCUM, no bubbles.
- Simultaneous Clear and Out_Ready in DONE: Clear wins. The result is still IDLE, but the frame counts as dropped.
- Release of Rst_N is asynchronous-assert only; the first accept is permitted on the first edge after deassertion.

## Test plan
- Reset: hold Rst_N=0 for 3 cycles with In_Valid=1 and In_Sum=5 -> Out_Valid=0, Out_Acc=0, Out_Sat=0 throughout. After release, In_Ready=1 and the first beat is accepted.
- Back-to-back frame (defaults): In_Sum=10,20,30,40 with In_Valid=1 for 4 consecutive cycles and Out_Ready=1 -> Out_Valid=1 for exactly one cycle, on the edge after the 4th beat. Expect Out_Acc=100, Out_Sat=0, In_Ready=0 that cycle.
- Stalls: beats 1,2,3,4 spaced with In_Valid=0 gaps, then Out_Ready=0 for 5 cycles -> Out_Acc=10 held stable and In_Ready=0 for all 5 cycles. When Out_Ready=1, expect IDLE on the next edge.
- Max input, no saturation (defaults): 4 beats of 511 -> Out_Acc=2044, Out_Sat=0.
- Saturation (ACC_W=10): 4 beats of 300 -> Out_Acc=1023, Out_Sat=1. The next frame of 1,1,1,1 gives Out_Acc=4, Out_Sat=0.
- Abort:
  - Accept 100 and 200, then Clear=1 for one cycle. Next frame 1,2,3,4 -> Out_Acc=10.
  - Separately, Clear in DONE with Out_Ready=1 -> no handshake; Out_Valid=0 next cycle.

Source files
------------

// File: rtl/sum_accumulator.sv
// sum_accumulator: frames COUNT adder results into one saturating total.
// Valid/ready on both sides; Clear aborts the frame in progress.
module sum_accumulator #(
  parameter int N     = 8,
  parameter int COUNT = 4,
  parameter int ACC_W = 11
) (
  input  logic             Clk,
  input  logic             Rst_N,
  input  logic [N:0]       In_Sum,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic             Clear,
  output logic [ACC_W-1:0] Out_Acc,
  output logic             Out_Sat,
  output logic             Out_Valid,
  input  logic             Out_Ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  localparam logic [7:0]       LP_COUNT = 8'(COUNT);
  localparam logic [ACC_W-1:0] LP_MAX   = '1;

  state_t           r_state;
  state_t           w_state_nx;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nx;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_nx;
  logic             r_sat;
  logic             w_sat_nx;

  logic [ACC_W-1:0] w_in_ext;
  logic [ACC_W:0]   w_sum;
  logic [7:0]       w_cnt_inc;
  logic             w_accept;

  assign w_in_ext  = ACC_W'(In_Sum);
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_in_ext};
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_accept  = In_Valid & In_Ready;

  assign In_Ready  = (r_state != S_DONE);
  assign Out_Valid = (r_state == S_DONE);
  assign Out_Acc   = r_acc;
  assign Out_Sat   = r_sat;

  // State, accumulator, beat count and sticky saturation registers
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_acc   <= w_acc_nx;
      r_cnt   <= w_cnt_nx;
      r_sat   <= w_sat_nx;
    end
  end

  // Next-state and datapath decode; Clear overrides everything
  always_comb begin
    w_state_nx = r_state;
    w_acc_nx   = r_acc;
    w_cnt_nx   = r_cnt;
    w_sat_nx   = r_sat;
    if (Clear) begin
      w_state_nx = S_IDLE;
      w_acc_nx   = '0;
      w_cnt_nx   = '0;
      w_sat_nx   = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_acc_nx   = w_in_ext;
            w_cnt_nx   = 8'd1;
            w_sat_nx   = 1'b0;
            w_state_nx = (LP_COUNT == 8'd1) ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            w_acc_nx = w_sum[ACC_W] ? LP_MAX : w_sum[ACC_W-1:0];
            w_sat_nx = r_sat | w_sum[ACC_W];
            w_cnt_nx = w_cnt_inc;
            if (w_cnt_inc == LP_COUNT) begin
              w_state_nx = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (Out_Ready) begin
            w_state_nx = S_IDLE;
            w_acc_nx   = '0;
            w_cnt_nx   = '0;
            w_sat_nx   = 1'b0;
          end
        end
        default: begin
          w_state_nx = S_IDLE;
          w_acc_nx   = '0;
          w_cnt_nx   = '0;
          w_sat_nx   = 1'b0;
        end
      endcase
    end
  end

endmodule
